// File: rtl/bf16_seq_pkg.sv
// Shared types and constants for the BF16 operation sequencer.
package bf16_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0]  OP_MIN    = 4'b0010;
    localparam logic [3:0]  OP_MAX    = 4'b0011;
    localparam logic [15:0] BF16_QNAN = 16'h7FC0;
    localparam int          FPCSR_W   = 4;

endpackage

// File: rtl/bf16_op_sequencer.sv
// Initiator for the bf16 accelerator operand/result interface: one command in
// flight, watchdog abort, sticky exception flags and a completed-op counter.
//
// state | meaning
// IDLE  | ready for a command, accelerator disabled
// BUSY  | operands held on acc_*, waiting for acc_valid or watchdog expiry
// RESP  | response held on rsp_*, waiting for rsp_ready
module bf16_op_sequencer
    import bf16_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TAG_W          = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [3:0]         cmd_op,
    input  logic [15:0]        cmd_a,
    input  logic [15:0]        cmd_b,
    input  logic [31:0]        cmd_c,
    input  logic [TAG_W-1:0]   cmd_tag,
    output logic               acc_enable,
    output logic [15:0]        acc_operand_a,
    output logic [15:0]        acc_operand_b,
    output logic [31:0]        acc_operand_c,
    output logic [3:0]         acc_operation,
    input  logic [15:0]        acc_result,
    input  logic [FPCSR_W-1:0] acc_fpcsr,
    input  logic               acc_valid,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [15:0]        rsp_result,
    output logic [FPCSR_W-1:0] rsp_fpcsr,
    output logic [TAG_W-1:0]   rsp_tag,
    output logic               rsp_timeout,
    output logic [FPCSR_W-1:0] flags_sticky,
    input  logic               flags_clr,
    output logic [15:0]        op_count
);

    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    state_t               state_q,   state_d;
    logic [3:0]           op_q,      op_d;
    logic [15:0]          a_q,       a_d;
    logic [15:0]          b_q,       b_d;
    logic [31:0]          c_q,       c_d;
    logic [TAG_W-1:0]     tag_q,     tag_d;
    logic [WD_W-1:0]      wd_q,      wd_d;
    logic [15:0]          result_q,  result_d;
    logic [FPCSR_W-1:0]   fpcsr_q,   fpcsr_d;
    logic                 timeout_q, timeout_d;
    logic [FPCSR_W-1:0]   flags_q,   flags_d;
    logic [15:0]          count_q,   count_d;

    // Next-state and datapath: latch on accept, capture or abort in BUSY, count on handshake.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        tag_d     = tag_q;
        wd_d      = wd_q;
        result_d  = result_q;
        fpcsr_d   = fpcsr_q;
        timeout_d = timeout_q;
        count_d   = count_q;
        // Clear first so a flag captured this same cycle still lands.
        flags_d   = flags_clr ? '0 : flags_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    c_d     = cmd_c;
                    tag_d   = cmd_tag;
                    wd_d    = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // A result arriving on the last watchdog cycle still beats the abort.
                if (acc_valid) begin
                    result_d  = acc_result;
                    fpcsr_d   = acc_fpcsr;
                    timeout_d = 1'b0;
                    flags_d   = flags_d | acc_fpcsr;
                    state_d   = RESP;
                end else if (wd_q == WD_LAST) begin
                    result_d  = BF16_QNAN;
                    fpcsr_d   = '0;
                    timeout_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    count_d = count_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            tag_q     <= '0;
            wd_q      <= '0;
            result_q  <= '0;
            fpcsr_q   <= '0;
            timeout_q <= 1'b0;
            flags_q   <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            tag_q     <= tag_d;
            wd_q      <= wd_d;
            result_q  <= result_d;
            fpcsr_q   <= fpcsr_d;
            timeout_q <= timeout_d;
            flags_q   <= flags_d;
            count_q   <= count_d;
        end
    end

    assign cmd_ready     = (state_q == IDLE);
    assign acc_enable    = (state_q == BUSY);
    assign rsp_valid     = (state_q == RESP);
    assign acc_operand_a = a_q;
    assign acc_operand_b = b_q;
    assign acc_operand_c = c_q;
    assign acc_operation = op_q;
    assign rsp_result    = result_q;
    assign rsp_fpcsr     = fpcsr_q;
    assign rsp_tag       = tag_q;
    assign rsp_timeout   = timeout_q;
    assign flags_sticky  = flags_q;
    assign op_count      = count_q;

endmodule

// File: tb/tb_bf16_op_sequencer.sv
// Bench for bf16_op_sequencer: stub accelerator with programmable latency,
// directed corner cases plus randomized commands against a transaction-level model.
module tb_bf16_op_sequencer;
    import bf16_seq_pkg::*;

    localparam int T = 16;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] c;
        logic [3:0]  tag;
        int          lat;   // cycles from acc_enable high to acc_valid; >=T+... means never in time
        logic [15:0] res;
        logic [3:0]  fcs;
        bit          clr;   // pulse flags_clr together with acc_valid
    } cmd_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic [31:0] cmd_c;
    logic [3:0]  cmd_tag;
    logic        acc_enable;
    logic [15:0] acc_operand_a;
    logic [15:0] acc_operand_b;
    logic [31:0] acc_operand_c;
    logic [3:0]  acc_operation;
    logic [15:0] acc_result = 16'h0;
    logic [3:0]  acc_fpcsr = 4'h0;
    logic        acc_valid = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic [3:0]  rsp_fpcsr;
    logic [3:0]  rsp_tag;
    logic        rsp_timeout;
    logic [3:0]  flags_sticky;
    logic        flags_clr = 1'b0;
    logic [15:0] op_count;

    int n_checks = 0;
    int n_err    = 0;

    // stub configuration, written by the main sequence
    int          stub_lat = 1000;
    logic [15:0] stub_res = 16'h0;
    logic [3:0]  stub_fcs = 4'h0;
    bit          stub_clr = 1'b0;
    bit          clr_req  = 1'b0;
    bit          spur     = 1'b0;
    int          st_cnt   = 0;
    bit          fire;

    // reference model state
    cmd_t        cur;
    logic [3:0]  flags_m;
    logic [15:0] count_m;

    always #5 clk = ~clk;

    bf16_op_sequencer #(.TIMEOUT_CYCLES(T), .TAG_W(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_c(cmd_c), .cmd_tag(cmd_tag),
        .acc_enable(acc_enable), .acc_operand_a(acc_operand_a), .acc_operand_b(acc_operand_b),
        .acc_operand_c(acc_operand_c), .acc_operation(acc_operation),
        .acc_result(acc_result), .acc_fpcsr(acc_fpcsr), .acc_valid(acc_valid),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_fpcsr(rsp_fpcsr), .rsp_tag(rsp_tag), .rsp_timeout(rsp_timeout),
        .flags_sticky(flags_sticky), .flags_clr(flags_clr), .op_count(op_count)
    );

    // Stub accelerator: counts enabled cycles, fires once after the programmed latency.
    // Outside a fire it drives junk result/fpcsr so stray captures are visible.
    always @(negedge clk) begin
        if (acc_enable) begin
            st_cnt = st_cnt + 1;
            fire   = (st_cnt == stub_lat + 1);
        end else begin
            st_cnt = 0;
            fire   = 1'b0;
        end
        acc_valid  = fire || spur;
        acc_result = fire ? stub_res : 16'hBAD0;
        acc_fpcsr  = fire ? stub_fcs : 4'hF;
        flags_clr  = (fire && stub_clr) || clr_req;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic cmd_t mk(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                input logic [31:0] c, input logic [3:0] tag, input int lat,
                                input logic [15:0] res, input logic [3:0] fcs, input bit clr);
        cmd_t k;
        k.op = op; k.a = a; k.b = b; k.c = c; k.tag = tag;
        k.lat = lat; k.res = res; k.fcs = fcs; k.clr = clr;
        return k;
    endfunction

    function automatic cmd_t rnd_cmd();
        return mk(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), $urandom,
                  4'($urandom_range(0, 15)), int'($urandom_range(0, 20)), 16'($urandom),
                  4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
    endfunction

    // Present a command; called away from clock edges.
    task automatic drive_cmd(input cmd_t k);
        cur       = k;
        cmd_op    = k.op;
        cmd_a     = k.a;
        cmd_b     = k.b;
        cmd_c     = k.c;
        cmd_tag   = k.tag;
        cmd_valid = 1'b1;
        stub_lat  = k.lat;
        stub_res  = k.res;
        stub_fcs  = k.fcs;
        stub_clr  = k.clr;
    endtask

    // Next edge accepts the presented command; accelerator side must show it.
    task automatic accept_check();
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("busy_enable", acc_enable, 1'b1);
        chk("busy_cmd_ready", cmd_ready, 1'b0);
        chk("busy_operation", acc_operation, cur.op);
        chk("busy_operand_a", acc_operand_a, cur.a);
        chk("busy_operand_b", acc_operand_b, cur.b);
        chk("busy_operand_c", acc_operand_c, cur.c);
    endtask

    // Wait for the response, compare with the model, hold it for `hold` cycles, then handshake.
    task automatic finish_cmd(input int hold, input bit queue, input cmd_t nxt);
        int          exp_cyc;
        bit          to;
        logic [15:0] exp_res;
        logic [3:0]  exp_f;
        logic [3:0]  exp_tag;
        int          cyc;
        to      = (cur.lat + 1 > T);
        exp_cyc = to ? T : cur.lat + 1;
        exp_res = to ? 16'h7FC0 : cur.res;
        exp_f   = to ? 4'h0 : cur.fcs;
        exp_tag = cur.tag;
        if (!to && cur.clr) flags_m = 4'h0;
        flags_m = flags_m | exp_f;

        cyc = 0;
        while (!rsp_valid && cyc < 64) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("rsp_latency", cyc, exp_cyc);
        chk("rsp_result", rsp_result, exp_res);
        chk("rsp_fpcsr", rsp_fpcsr, exp_f);
        chk("rsp_timeout", rsp_timeout, to);
        chk("rsp_tag", rsp_tag, exp_tag);
        chk("flags_sticky", flags_sticky, flags_m);
        chk("resp_enable_low", acc_enable, 1'b0);

        if (queue) drive_cmd(nxt);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", rsp_valid, 1'b1);
            chk("hold_result", rsp_result, exp_res);
            chk("hold_tag", rsp_tag, exp_tag);
            chk("hold_cmd_ready", cmd_ready, 1'b0);
            chk("hold_count", op_count, count_m);
        end

        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        count_m   = count_m + 16'd1;
        chk("hs_rsp_valid", rsp_valid, 1'b0);
        chk("hs_op_count", op_count, count_m);
        chk("hs_cmd_ready", cmd_ready, 1'b1);
        chk("hs_enable", acc_enable, 1'b0);
    endtask

    task automatic run_op(input cmd_t k, input int hold);
        drive_cmd(k);
        accept_check();
        finish_cmd(hold, 1'b0, k);
    endtask

    task automatic check_reset_state(input string pfx);
        chk({pfx, "_cmd_ready"}, cmd_ready, 1'b1);
        chk({pfx, "_enable"}, acc_enable, 1'b0);
        chk({pfx, "_rsp_valid"}, rsp_valid, 1'b0);
        chk({pfx, "_flags"}, flags_sticky, 4'h0);
        chk({pfx, "_op_count"}, op_count, 16'h0);
        chk({pfx, "_operand_a"}, acc_operand_a, 16'h0);
        chk({pfx, "_operation"}, acc_operation, 4'h0);
        chk({pfx, "_rsp_result"}, rsp_result, 16'h0);
        chk({pfx, "_rsp_timeout"}, rsp_timeout, 1'b0);
    endtask

    initial begin
        cmd_t q;
        int   seen;
        reset_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_c = '0; cmd_tag = '0;
        flags_m = 4'h0; count_m = 16'h0;
        cur = mk(4'h0, 16'h0, 16'h0, 32'h0, 4'h0, 1000, 16'h0, 4'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;

        // min, L=3: response 4 cycles after acceptance
        run_op(mk(OP_MIN, 16'h4000, 16'h3F80, 32'h0, 4'h1, 3, 16'h3F80, 4'h0, 1'b0), 0);
        // max with NaN operand, invalid flag raised
        run_op(mk(OP_MAX, 16'h7F80, 16'h7FC0, 32'h0, 4'h2, 2, 16'h7F80, 4'b1000, 1'b0), 1);

        // clear while idle
        clr_req = 1'b1;
        @(posedge clk); #1;
        clr_req = 1'b0;
        flags_m = 4'h0;
        chk("idle_clear", flags_sticky, 4'h0);

        // acc_valid outside BUSY is ignored
        spur = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        spur = 1'b0;
        chk("spur_no_rsp", rsp_valid, 1'b0);
        chk("spur_flags", flags_sticky, flags_m);
        chk("spur_count", op_count, count_m);

        // watchdog: no result ever, just at the limit, one past the limit
        run_op(mk(4'h5, 16'h1111, 16'h2222, 32'h3333_4444, 4'h3, 1000, 16'h0, 4'h0, 1'b0), 0);
        run_op(mk(4'h6, 16'h1234, 16'h5678, 32'h9ABC_DEF0, 4'h4, T - 1, 16'h4321, 4'b0001, 1'b0), 0);
        run_op(mk(4'h7, 16'hAAAA, 16'h5555, 32'h0, 4'h5, T, 16'h9999, 4'b0100, 1'b0), 0);

        // clear coinciding with a capture keeps the new flag
        run_op(mk(4'h1, 16'h0001, 16'h0002, 32'h0, 4'h6, 1, 16'h0003, 4'b0100, 1'b0), 0);
        run_op(mk(4'h8, 16'h0004, 16'h0005, 32'h0, 4'h7, 2, 16'h0006, 4'b0010, 1'b1), 0);
        chk("clr_capture", flags_sticky, 4'b0010);

        // backpressure with a queued command accepted one cycle after the handshake
        q = mk(OP_MIN, 16'hC000, 16'h4040, 32'h0, 4'h9, 4, 16'hC000, 4'h0, 1'b0);
        drive_cmd(mk(4'h9, 16'h3C00, 16'h3D00, 32'h1, 4'h8, 0, 16'h3E00, 4'h0, 1'b0));
        accept_check();
        finish_cmd(5, 1'b1, q);
        accept_check();
        finish_cmd(0, 1'b0, q);

        // randomized traffic
        for (int i = 0; i < 30; i++) run_op(rnd_cmd(), int'($urandom_range(0, 3)));

        // reset in the middle of an op: no response must follow
        drive_cmd(mk(4'hA, 16'hFFFF, 16'hEEEE, 32'hDDDD_CCCC, 4'hB, 1000, 16'h0, 4'h0, 1'b0));
        accept_check();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        flags_m = 4'h0;
        count_m = 16'h0;
        check_reset_state("midreset");
        seen = 0;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        chk("midreset_no_rsp", seen, 0);
        run_op(mk(OP_MAX, 16'h3F80, 16'h4000, 32'h0, 4'hC, 5, 16'h4000, 4'b0010, 1'b0), 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
